// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 decryption round-key generator: runs the forward schedule to key 10, then streams keys 10..0 by inverting the recurrence.
// Optional key self-check (shadow copy of the cipher key) is built when AES_INV_KEY_CHECK_EN is defined.
module aes_inv_key_schedule #(
  parameter int WIDTH  = 128,
  parameter int ROUNDS = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] key_ciph_i,
  output logic             busy_o,
  output logic             rkey_valid_o,
  input  logic             rkey_ready_i,
  output logic [WIDTH-1:0] rkey_o,
  output logic [3:0]       rkey_idx_o,
  output logic             last_o,
  output logic             done_o,
  output logic             key_err_o
);

  // Handshake: a round key transfers on a rising edge where rkey_valid_o && rkey_ready_i;
  // while valid is high and ready is low, rkey_o and rkey_idx_o do not change.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(ROUNDS);

  // Forward AES S-box, byte 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             done_q, done_d;

  logic [31:0] w0, w1, w2, w3, p3;
  logic [31:0] sub_in, rot, sub_out, t_word;
  logic [3:0]  rcon_idx;
  logic [WIDTH-1:0] fwd_key, inv_key;
  logic        start_ok, final_acc;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];
  assign p3 = w3 ^ w2;

  // The single S-box serves w3 going forward and the recovered w3 (p3) going backward.
  assign sub_in   = (state_q == EMIT) ? p3 : w3;
  assign rot      = {sub_in[23:0], sub_in[31:24]};
  assign sub_out  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign rcon_idx = (state_q == EMIT) ? (rnd_q - 4'd1) : rnd_q;
  assign t_word   = sub_out ^ {rcon(rcon_idx), 24'h000000};

  always_comb begin
    logic [31:0] n0, n1, n2, n3;
    n0 = w0 ^ t_word;
    n1 = n0 ^ w1;
    n2 = n1 ^ w2;
    n3 = n2 ^ w3;
    fwd_key = {n0, n1, n2, n3};
    inv_key = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, p3};
  end

  assign start_ok  = (state_q == IDLE) && start_i;
  assign final_acc = (state_q == EMIT) && rkey_ready_i && (rnd_q == 4'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    key_d   = key_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          key_d   = key_ciph_i;
          rnd_d   = 4'd0;
          state_d = FWD;
        end
      end
      FWD: begin
        // One extra cycle at rnd==10 to hand over to EMIT, giving the 11-cycle start-to-valid latency.
        if (rnd_q == LAST_RND) begin
          state_d = EMIT;
        end else begin
          key_d = fwd_key;
          rnd_d = rnd_q + 4'd1;
        end
      end
      EMIT: begin
        if (rkey_ready_i) begin
          if (rnd_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = inv_key;
            rnd_d = rnd_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o       = (state_q != IDLE);
  assign rkey_valid_o = (state_q == EMIT);
  assign rkey_o       = key_q;
  assign rkey_idx_o   = rnd_q;
  assign last_o       = (state_q == EMIT) && (rnd_q == 4'd0);
  assign done_o       = done_q;

`ifdef AES_INV_KEY_CHECK_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             err_q, err_d;

  always_comb begin
    shadow_d = shadow_q;
    err_d    = err_q;
    if (start_ok) begin
      shadow_d = key_ciph_i;
      err_d    = 1'b0;
    end else if (final_acc && (key_q != shadow_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign key_err_o = err_q;
`else
  logic unused_ok;
  assign unused_ok = start_ok ^ final_acc;
  assign key_err_o = 1'b0 & unused_ok;
`endif

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: known-answer table, model-checked streams with stalls and ignored starts, async reset abort.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         ready = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, valid, last, done, key_err;
  logic [127:0] rkey;
  logic [3:0]   idx;

  aes_inv_key_schedule #(.WIDTH(128), .ROUNDS(10)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .key_ciph_i   (key_in),
    .busy_o       (busy),
    .rkey_valid_o (valid),
    .rkey_ready_i (ready),
    .rkey_o       (rkey),
    .rkey_idx_o   (idx),
    .last_o       (last),
    .done_o       (done),
    .key_err_o    (key_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] model_rk [11];
  logic [127:0] exp_q [$];

  typedef struct {
    logic [127:0] key;
    logic [127:0] k10;
    logic [127:0] k1;
  } vec_t;
  vec_t vecs [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired waiting for DUT", name);
  endtask

  // reference model: GF(2^8) arithmetic, S-box from inverse + affine map, textbook expansion
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // driver: known-answer vector, ready held high
  task automatic run_table(input vec_t v);
    int cyc;
    bit seen0;
    @(negedge clk); key_in = v.key; start = 1'b1; ready = 1'b0;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!valid && cyc < 40) begin @(negedge clk); cyc++; end
    if (!valid) fail_now("tbl_wait_valid");
    check("tbl_k10", rkey, v.k10);
    check("tbl_idx10", idx, 10);
    ready = 1'b1;
    cyc = 0; seen0 = 1'b0;
    while (!seen0 && cyc < 40) begin
      if (valid && idx == 4'd1) check("tbl_k1", rkey, v.k1);
      if (valid && idx == 4'd0) begin
        check("tbl_k0", rkey, v.key);
        check("tbl_last", last, 1);
        seen0 = 1'b1;
      end
      @(negedge clk); cyc++;
    end
    if (!seen0) fail_now("tbl_wait_idx0");
    ready = 1'b0;
    @(negedge clk);
  endtask

  // driver + scoreboard: mode 0 ready high, 1 random ready, 2 hold ready low 3 cycles at idx 7
  task automatic run_key(input logic [127:0] key, input int mode, input bit poke);
    int lat, xfers, dones, cyc, hold;
    logic [127:0] pk, e;
    logic [3:0]   pidx;
    bit           pstall;
    model_expand(key);
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back(model_rk[r]);
    @(negedge clk); key_in = key; start = 1'b1; ready = 1'b0;
    @(negedge clk); start = 1'b0; key_in = rand_key();
    lat = 0;
    while (!valid && lat < 40) begin
      check("busy_fwd", busy, 1);
      if (poke && lat == 4) begin start = 1'b1; key_in = rand_key(); end
      else start = 1'b0;
      @(negedge clk); lat++;
    end
    start = 1'b0;
    check("latency", lat, 11);
    xfers = 0; dones = 0; pstall = 1'b0; hold = 0; cyc = 0; pk = '0; pidx = '0;
    while (xfers < 11 && cyc < 300) begin
      if (pstall) begin
        check("stall_key_stable", rkey, pk);
        check("stall_idx_stable", idx, pidx);
      end
      check("valid_emit", valid, 1);
      check("busy_emit", busy, 1);
      case (mode)
        1:       ready = 1'($urandom_range(0, 1));
        2:       if (idx == 4'd7 && hold < 3) begin ready = 1'b0; hold++; end else ready = 1'b1;
        default: ready = 1'b1;
      endcase
      if (poke && (xfers == 5 || xfers == 10)) begin start = 1'b1; key_in = rand_key(); end
      else start = 1'b0;
      if (ready) begin
        if (exp_q.size() == 0) fail_now("extra_transfer");
        else begin
          e = exp_q.pop_front();
          check("rkey", rkey, e);
          check("rkey_idx", idx, 10 - xfers);
          check("last", last, (xfers == 10));
        end
        xfers++;
      end
      if (done) dones++;
      pstall = !ready; pk = rkey; pidx = idx;
      @(negedge clk); cyc++;
    end
    start = 1'b0; ready = 1'b0;
    check("transfers", xfers, 11);
    check("done_during_stream", dones, 0);
    check("done_pulse", done, 1);
    check("valid_after_last", valid, 0);
    check("busy_after_last", busy, 0);
    check("key_err_clean", key_err, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("start_at_last_ignored", busy, 0);
  endtask

  initial begin
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{128'h00000000000000000000000000000000, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 128'h62636363626363636263636362636363};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h13111d7fe3944a17f307a78b4d2b30c5, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    build_sbox();

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_rkey", rkey, 0);
    check("rst_idx", idx, 0);
    check("rst_last", last, 0);
    check("rst_done", done, 0);
    check("rst_key_err", key_err, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) run_table(vecs[i]);

    run_key(vecs[0].key, 0, 1'b0);
    run_key(vecs[0].key, 2, 1'b1);

    // reset asserted mid-stream at idx 5
    begin
      int cyc;
      @(negedge clk); key_in = vecs[0].key; start = 1'b1;
      @(negedge clk); start = 1'b0; ready = 1'b1;
      cyc = 0;
      while (!(valid && idx == 4'd5) && cyc < 60) begin @(negedge clk); cyc++; end
      if (!(valid && idx == 4'd5)) fail_now("wait_idx5");
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_valid", valid, 0);
      check("arst_rkey", rkey, 0);
      check("arst_idx", idx, 0);
      check("arst_last", last, 0);
      check("arst_done", done, 0);
      check("arst_key_err", key_err, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0; ready = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("no_partial_after_rst", valid, 0);
      end
      ready = 1'b0;
    end
    run_table(vecs[1]);

    for (int i = 0; i < 4; i++) run_key(rand_key(), 1, 1'b1);

`ifdef AES_INV_KEY_CHECK_EN
    // corrupt the working key while the stream is stalled; the self-check must flag it
    begin
      int cyc;
      logic [127:0] tmp;
      @(negedge clk); key_in = vecs[0].key; start = 1'b1;
      @(negedge clk); start = 1'b0; ready = 1'b1;
      cyc = 0;
      while (!(valid && idx == 4'd6) && cyc < 60) begin @(negedge clk); cyc++; end
      ready = 1'b0;
      tmp = dut.key_q;
      tmp[0] = ~tmp[0];
      force dut.key_q = tmp;
      @(negedge clk);
      release dut.key_q;
      ready = 1'b1;
      cyc = 0;
      while (!done && cyc < 60) begin @(negedge clk); cyc++; end
      ready = 1'b0;
      if (!done) fail_now("err_wait_done");
      check("key_err_set", key_err, 1);
      repeat (2) @(negedge clk);
      check("key_err_sticky", key_err, 1);
      key_in = vecs[0].key; start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("key_err_cleared", key_err, 0);
      cyc = 0;
      while (!valid && cyc < 40) begin @(negedge clk); cyc++; end
      ready = 1'b1;
      cyc = 0;
      while (!done && cyc < 60) begin @(negedge clk); cyc++; end
      ready = 1'b0;
      check("key_err_good_run", key_err, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Iterative AES-128 round-key generator for the decryption datapath; the reverse-order counterpart of the forward key expansion used by the encryptor.
- Accepts the cipher key and runs the forward schedule internally to reach round key 10.
- Then streams round keys 10 down to 0 over a valid/ready handshake, regenerating each previous key with the inverse recurrence.
- Needs only one 128-bit working register and one shared S-box, instead of 11 stored keys.

Parameters:
WIDTH, 128, key/round-key width; only 128 is supported.
ROUNDS, 10, number of AES-128 rounds; fixes the index range 10..0.

Ports:
clk_i  input  1  clock, all state updates on its rising edge.
rst_i  input  1  reset, asynchronous, active-high.
start_i  input  1  one-cycle request; samples key_ciph_i; honoured only in IDLE.
key_ciph_i  input  WIDTH  cipher key, word 0 in bits [127:96].
busy_o  output  1  high in every state other than IDLE.
rkey_valid_o  output  1  rkey_o/rkey_idx_o hold a valid round key.
rkey_ready_i  input  1  consumer accepts the current key.
rkey_o  output  WIDTH  current round key.
rkey_idx_o  output  4  round index of rkey_o (10..0).
last_o  output  1  high with rkey_valid_o when rkey_idx_o==0.
done_o  output  1  one-cycle pulse after the index-0 key is accepted.
key_err_o  output  1  see Optional Feature.

Behaviour:
- Reset (rst_i high, asynchronous): state=IDLE; rnd=0; working key=0.
  - All outputs 0: busy_o, rkey_valid_o, rkey_o, rkey_idx_o, last_o, done_o, key_err_o.
  - Reset asserted mid-operation aborts immediately; no partial keys are emitted afterwards.
- States: IDLE, FWD, EMIT.
- IDLE:
  - start_i=1 loads key_ciph_i into the working key, sets rnd=0, and goes to FWD.
  - start_i is ignored in FWD and EMIT.
- FWD: one forward round per cycle.
  - Next key words: t = SubWord(RotWord(w3)) ^ rcon[rnd]; n0 = w0^t; n1 = n0^w1; n2 = n1^w2; n3 = n2^w3.
  - rnd increments each cycle. After 10 cycles (rnd reaches 10) go to EMIT with rkey_idx_o=10.
- rcon[r] for r=0..9: 01,02,04,08,10,20,40,80,1b,36, placed in the top byte of the word.
- Latency: start_i sampled at edge t gives rkey_valid_o=1 after edge t+11.
- EMIT:
  - rkey_valid_o=1. rkey_o and rkey_idx_o stay stable while rkey_ready_i=0.
  - On valid&ready with idx>0, compute the previous key in one cycle:
    - p3 = w3^w2; p2 = w2^w1; p1 = w1^w0.
    - p0 = w0 ^ SubWord(RotWord(p3)) ^ rcon[idx-1].
    - Decrement idx. rkey_valid_o stays 1, so back-to-back transfers at one key per cycle are possible.
  - On valid&ready with idx==0: go to IDLE, rkey_valid_o=0, done_o=1 for exactly one cycle.
  - A start_i in that same cycle is ignored; start_i in the following IDLE cycle is accepted.
- Total of 11 handshakes per start. The key stream is 10,9,...,0 with no gaps and no duplicates.
- Arithmetic: GF(2^8) operations only through the S-box and XOR; widths never change.
- S-box: a single combinational AES forward S-box instance (4 byte lanes), shared by FWD and EMIT.

Optional Feature:
- Macro: AES_INV_KEY_CHECK_EN.
- Defined:
  - key_ciph_i is additionally captured into a 128-bit shadow register on start.
  - When the index-0 key is accepted, it is compared with the shadow value.
  - A mismatch sets key_err_o=1. key_err_o is sticky until the next accepted start or reset.
- Not defined: no shadow register is built; key_err_o is tied to 0.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, rkey_ready_i=1 → after 11 cycles rkey_idx_o=10, rkey_o=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same run continued → idx 1 gives a0fafe1788542cb123a339392a6c7605; idx 0 gives 2b7e1516...09cf4f3c with last_o=1; done_o pulses once; 11 transfers total.
- Random ready stalls (e.g. ready low 3 cycles at idx 7) → rkey_o/idx held stable; sequence identical to the unstalled run.
- start_i pulsed during FWD and during EMIT → ignored; stream unchanged; busy_o=1 throughout.
- rst_i asserted at idx 5 → all outputs 0 asynchronously; a new start with key 000...0 gives idx 10 key b4ef5bcb3e92e21123e951cf6f8f188e.
- With AES_INV_KEY_CHECK_EN: normal run → key_err_o=0. Forced flip of the working key bit 0 mid-EMIT → key_err_o=1 after idx 0, cleared by the next start.
